// File: rtl/cmplxmul_arb.sv
// Shares one complex multiplier between NREQ requesters with round-robin grant and a PIPE-deep result pipe.
// Build option: define CMUL_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins, no rotation pointer).
module cmplxmul_arb #(
  parameter int DBW  = 3,
  parameter int NREQ = 4,
  parameter int PIPE = 2,
  localparam int IDW = $clog2(NREQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ*2*DBW-1:0]  req_op1,
  input  logic [NREQ*2*DBW-1:0]  req_op2,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [4*DBW-1:0]       res_prod,
  output logic [IDW-1:0]         res_id
);

  logic [PIPE-1:0]    vld_q, vld_d;
  logic [4*DBW-1:0]   prod_q [PIPE];
  logic [4*DBW-1:0]   prod_d [PIPE];
  logic [IDW-1:0]     id_q   [PIPE];
  logic [IDW-1:0]     id_d   [PIPE];

  logic               stall;
  logic               found;
  logic               xfer;
  logic [IDW-1:0]     win_idx;
  int                 idx;

`ifndef CMUL_ARB_FIXED_PRIO_EN
  logic [IDW-1:0]     ptr_q, ptr_d;
`endif

  assign res_valid = vld_q[PIPE-1];
  assign res_prod  = prod_q[PIPE-1];
  assign res_id    = id_q[PIPE-1];
  assign stall     = res_valid & ~res_ready;

  // First asserted request at or after the search start wins.
  always_comb begin
    found   = 1'b0;
    win_idx = '0;
    idx     = 0;
    for (int k = 0; k < NREQ; k++) begin
`ifdef CMUL_ARB_FIXED_PRIO_EN
      idx = k;
`else
      idx = (int'(ptr_q) + k) % NREQ;
`endif
      if (!found && req_valid[idx]) begin
        found   = 1'b1;
        win_idx = IDW'(idx);
      end
    end
  end

  assign xfer = found & ~stall & rst_n;

  always_comb begin
    req_ready = '0;
    if (xfer) req_ready[win_idx] = 1'b1;
  end

`ifndef CMUL_ARB_FIXED_PRIO_EN
  always_comb begin
    ptr_d = ptr_q;
    if (xfer) begin
      if (int'(win_idx) == NREQ - 1) ptr_d = '0;
      else                           ptr_d = win_idx + 1'b1;
    end
  end
`endif

  logic [2*DBW-1:0]        op1_sel, op2_sel;
  logic signed [2*DBW-1:0] a_re, a_im, b_re, b_im;
  logic signed [2*DBW-1:0] mul_re, mul_im;

  always_comb begin
    op1_sel = '0;
    op2_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (int'(win_idx) == i) begin
        op1_sel = req_op1[i*2*DBW +: 2*DBW];
        op2_sel = req_op2[i*2*DBW +: 2*DBW];
      end
    end
  end

  // Operands are sign-extended to the product width so the sums wrap modulo 2^(2*DBW).
  always_comb begin
    a_re   = {{DBW{op1_sel[DBW-1]}},   op1_sel[DBW-1:0]};
    a_im   = {{DBW{op1_sel[2*DBW-1]}}, op1_sel[2*DBW-1:DBW]};
    b_re   = {{DBW{op2_sel[DBW-1]}},   op2_sel[DBW-1:0]};
    b_im   = {{DBW{op2_sel[2*DBW-1]}}, op2_sel[2*DBW-1:DBW]};
    mul_re = a_re * b_re - a_im * b_im;
    mul_im = a_re * b_im + a_im * b_re;
  end

  always_comb begin
    vld_d  = vld_q;
    prod_d = prod_q;
    id_d   = id_q;
    if (!stall) begin
      vld_d[0]  = xfer;
      prod_d[0] = {mul_re, mul_im};
      id_d[0]   = win_idx;
      for (int s = 1; s < PIPE; s++) begin
        vld_d[s]  = vld_q[s-1];
        prod_d[s] = prod_q[s-1];
        id_d[s]   = id_q[s-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int s = 0; s < PIPE; s++) begin
        prod_q[s] <= '0;
        id_q[s]   <= '0;
      end
`ifndef CMUL_ARB_FIXED_PRIO_EN
      ptr_q <= '0;
`endif
    end else begin
      vld_q <= vld_d;
      for (int s = 0; s < PIPE; s++) begin
        prod_q[s] <= prod_d[s];
        id_q[s]   <= id_d[s];
      end
`ifndef CMUL_ARB_FIXED_PRIO_EN
      ptr_q <= ptr_d;
`endif
    end
  end

`ifndef SYNTHESIS
  a_ready_onehot: assert property (@(posedge clk) $onehot0(req_ready));
  a_stall_hold: assert property (@(posedge clk) disable iff (!rst_n)
    stall |=> (res_valid && $stable(res_prod) && $stable(res_id)));
`endif

endmodule
